shift_add_mult: RTL and testbench
=================================

// Module: shift_add_mult
// PURPOSE
//  Sequential unsigned WIDTH x WIDTH shift-and-add multiplier; consumer of the ripple-carry adder stage.
//  Each RUN cycle, one adder pass adds (multiplicand or 0) into the upper accumulator; carry-out feeds the shift.
//  start/busy/done control handshake; 2*WIDTH-bit product held until the next accepted start.
// PARAMETERS
//  WIDTH  8  operand width in bits; product width is 2*WIDTH; WIDTH >= 2
// PORTS
//  clk      in   1        single clock, rising edge
//  rst_n    in   1        synchronous, active-low reset
//  start    in   1        request; sampled only in IDLE or DONE
//  a        in   WIDTH    multiplicand, captured on accepted start
//  b        in   WIDTH    multiplier, captured on accepted start
//  busy     out  1        high while in RUN
//  done     out  1        one-cycle pulse; product valid from this cycle onward
//  product  out  2*WIDTH  result register, updated only on entry to DONE
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, busy=0, done=0, product=0, cnt=0, acc=0, mq=0, mcand=0.
//  Reset mid-RUN aborts the operation; no done pulse; product clears to 0.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: start=1 -> load mcand=a, mq=b, acc=0, cnt=0; next state RUN. Otherwise stay in IDLE.
//   RUN: busy=1. Each cycle {c,sum} = acc + (mq[0] ? mcand : 0), computed by the adder sub-module with Ci=0.
//        Then {acc,mq} <= {c,sum,mq[WIDTH-1:1]} and cnt <= cnt+1.
//        After the WIDTH-th RUN cycle: product <= {acc,mq} post-shift; next state DONE.
//   DONE: done=1, busy=0 for exactly 1 cycle.
//        start=1 -> reload operands, next state RUN (back-to-back ops, no idle bubble).
//        Otherwise next state IDLE.
//  Latency: start sampled at edge T -> busy high T+1..T+WIDTH -> done high in cycle T+WIDTH+1.
//  Throughput: one result per WIDTH+1 cycles.
//  start is ignored during RUN; operand changes on a/b during RUN have no effect.
//  Arithmetic: unsigned only. Adder carry-out is never dropped; max result (2^W-1)^2 fits in 2*WIDTH bits.
//  cnt width is $clog2(WIDTH+1); cnt does not wrap inside one operation.
//  product keeps its last value through IDLE and RUN; it changes only on DONE entry or reset.
// CONFIGURATION
//  Macro EARLY_TERM_EN.
//  Defined: on an accepted start with a==0 or b==0, RUN is skipped.
//   FSM goes directly to DONE with product <= 0. done is high in cycle T+1; busy stays 0.
//  Undefined: every operation takes the full WIDTH RUN cycles, including zero operands.
//  Results are identical in both builds; only latency differs.
// STRUCTURE
//  Shared package mult_pkg:
//   - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
//   - default width constant MULT_W=8
//  Sub-module rca_add: WIDTH-bit ripple-carry adder (ports Sum, Co, A, B, Ci), one full adder per bit.
//   Instantiated once; its carry-out bit drives c.
//  All registers reside in shift_add_mult. No other hierarchy.
// TESTING
//  1) a=13, b=11, start pulse -> busy high for 8 cycles; done at T+9; product=16'd143.
//  2) a=255, b=255 -> product=16'hFE01 (65025); checks the carry-out path.
//  3) a=0, b=200 -> product=0; done at T+9 without EARLY_TERM_EN, at T+1 with it (busy never high).
//  4) start held high continuously, a=3, b=5 then a=7, b=9 at DONE:
//     done pulses 9 cycles apart; product 15 then 63; start during RUN ignored.
//  5) rst_n=0 at the 4th RUN cycle of a=100, b=100 -> next cycle IDLE, busy=0, done=0, product=0; no done pulse.
//  6) Random 1000 pairs vs a*b reference model, both macro builds; assert done is exactly 1 cycle wide.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants for the shift-and-add multiplier: FSM state encoding and
// the default operand width.
package mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int MULT_W = 8;

endpackage

// File: rtl/rca_add.sv
// WIDTH-bit ripple-carry adder built from one full adder per bit.
// Purely combinational; the carry chain runs from bit 0 upward.
module rca_add #(
  parameter int WIDTH = 8
) (
  output logic [WIDTH-1:0] Sum,
  output logic             Co,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci
);

  logic [WIDTH:0] carry;

  assign carry[0] = Ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign Sum[i]     = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign Co = carry[WIDTH];

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier.
// One rca_add pass per RUN cycle adds (mcand or 0) into the upper half of
// the {acc,mq} register pair; the adder carry becomes the new top bit as the
// pair shifts right.
//
// Optional build macro: EARLY_TERM_EN -- when defined, an accepted start with
// a zero operand skips RUN and goes straight to DONE with product 0.
//
// Handshake: start is a request sampled only in IDLE or DONE (accepted at the
// rising edge where it is seen high in those states); busy is high exactly
// while the FSM is in RUN; done is a one-cycle pulse in the DONE state, and
// product is valid from that cycle until the next DONE entry or reset.
module shift_add_mult import mult_pkg::*; #(
  parameter int WIDTH = MULT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mq;
  logic [WIDTH-1:0]   mcand;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               c;
  logic [2*WIDTH-1:0] shifted;
  logic               zero_op;

  // Multiplier LSB selects whether the multiplicand is added this pass.
  assign addend = mq[0] ? mcand : '0;

  rca_add #(
    .WIDTH (WIDTH)
  ) u_add (
    .Sum (sum),
    .Co  (c),
    .A   (acc),
    .B   (addend),
    .Ci  (1'b0)
  );

  // Carry-out is kept as the new MSB, so no product bit is ever lost.
  assign shifted = {c, sum, mq[WIDTH-1:1]};

`ifdef EARLY_TERM_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // FSM, datapath registers and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      acc     <= '0;
      mq      <= '0;
      mcand   <= '0;
      product <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            mcand <= a;
            mq    <= b;
            acc   <= '0;
            cnt   <= '0;
            if (zero_op) begin
              product <= '0;
              state   <= ST_DONE;
            end else begin
              state   <= ST_RUN;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          {acc, mq} <= shifted;
          cnt       <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            product <= shifted;
            state   <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult: directed cases, start held high,
// reset mid-operation and randomized operand pairs checked against a*b.
module tb_shift_add_mult;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;

  int            n_checks;
  int            n_errors;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] held_prod;
  logic          prev_done;

  shift_add_mult #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // done must never stay high for two consecutive cycles
  initial begin
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done) check("done_width", {31'd0, done}, 32'd0);
      prev_done = done;
    end
  end

  function automatic logic [PW-1:0] ref_mult(input logic [W-1:0] x, input logic [W-1:0] y);
    int p;
    p = int'(x) * int'(y);
    return PW'(p);
  endfunction

  function automatic int exp_latency(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef EARLY_TERM_EN
    if (x == 0 || y == 0) return 1;
`endif
    return W + 1;
  endfunction

  // driver: one operation with a single-cycle start pulse
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
    int            lat;
    int            busy_cnt;
    logic          got_done;
    logic [PW-1:0] exp;
    exp_q.push_back(ref_mult(x, y));
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    lat = 0;
    busy_cnt = 0;
    got_done = 1'b0;
    for (int k = 1; k <= 40 && !got_done; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      if (busy) busy_cnt++;
      if (!done && k == 1) check("prod_hold", 32'(product), 32'(held_prod));
      if (done) begin
        got_done = 1'b1;
        lat = k;
        check("product", 32'(product), 32'(exp_q[0]));
      end
    end
    exp = exp_q.pop_front();
    held_prod = exp;
    if (!got_done) begin
      check("timeout", 32'd0, 32'd1);
    end else begin
      check("latency", 32'(lat), 32'(exp_latency(x, y)));
      check("busy_cycles", 32'(busy_cnt), 32'(exp_latency(x, y) - 1));
    end
  endtask

  // wait for done while start stays asserted; returns cycles waited
  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        cycles = k;
        break;
      end
    end
    if (cycles == 0) check("timeout_held", 32'd0, 32'd1);
  endtask

  initial begin
    int            cyc;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    n_checks  = 0;
    n_errors  = 0;
    held_prod = '0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_product", 32'(product), 32'd0);
    rst_n = 1'b1;

    // directed cases
    run_op(8'd13, 8'd11);
    check("p_13x11", 32'(held_prod), 32'd143);
    run_op(8'd255, 8'd255);
    run_op(8'd0, 8'd200);
    run_op(8'd200, 8'd0);

    // start held high: back-to-back operations
    @(negedge clk);
    a = 8'd3;
    b = 8'd5;
    start = 1'b1;
    wait_done(cyc);
    check("held_prod1", 32'(product), 32'(ref_mult(8'd3, 8'd5)));
    a = 8'd7;
    b = 8'd9;
    wait_done(cyc);
    check("held_gap", 32'(cyc), 32'(W + 1));
    check("held_prod2", 32'(product), 32'(ref_mult(8'd7, 8'd9)));
    start = 1'b0;
    held_prod = ref_mult(8'd7, 8'd9);

    // reset in the 4th RUN cycle
    @(negedge clk);
    a = 8'd100;
    b = 8'd100;
    start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    check("mid_busy", {31'd0, busy}, 32'd1);
    check("mid_prod_held", 32'(product), 32'(held_prod));
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_product", 32'(product), 32'd0);
    rst_n = 1'b1;
    held_prod = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("no_done", {31'd0, done}, 32'd0);
    end

    // randomized operands
    for (int n = 0; n < 1000; n++) begin
      x = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(0, 255));
      y = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(0, 255));
      run_op(x, y);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
